// File: rtl/mem_fetch_seq.sv
// mem_fetch_seq: walks word addresses of a combinational ROM, samples each
// word in the cycle its address is presented, and hands {address, word}
// pairs to a downstream consumer over a valid/ready handshake.
module mem_fetch_seq #(
  parameter int DEPTH      = 10,
  parameter int START_ADDR = 0,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              jump_en,
  input  logic [31:0]       jump_addr,
  output logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              wrap,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam logic [31:0] LAST    = 32'(DEPTH - 1);
  localparam logic [31:0] START_U = 32'(START_ADDR);

  state_t      state;
  logic [31:0] pc;
  logic        xfer;
  logic        cap;

  // Handshake and capture qualifiers derived from the current registers.
  always_comb begin
    xfer = out_valid && out_ready;
    cap  = (state == RUN) && !jump_en && (!out_valid || out_ready);
  end

  // The ROM is always addressed by the PC; busy mirrors the state register.
  always_comb begin
    mem_addr = pc;
    busy     = (state != IDLE);
  end

  // Single state machine: capture path, PC sequencing, jumps and state moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= START_U;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      wrap      <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (xfer) begin
        out_valid <= 1'b0;
      end
      if (cap) begin
        out_data  <= mem_data;
        out_addr  <= pc;
        out_valid <= 1'b1;
        if (pc == LAST) begin
          pc   <= '0;
          wrap <= 1'b1;
        end else begin
          pc <= pc + 32'd1;
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            pc       <= START_U;
            addr_err <= 1'b0;
          end
        end
        RUN: begin
          if (jump_en) begin
            if (jump_addr < DEPTH_U) begin
              pc <= jump_addr;
            end else begin
              addr_err <= 1'b1;
            end
          end
          if (stop) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!out_valid || out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fetch_seq.sv
// Directed bench for mem_fetch_seq with a 10-word ROM image held in the bench.
module tb_mem_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        wrap;
  logic        addr_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] rom_img [10];

  mem_fetch_seq #(.DEPTH(10), .START_ADDR(0), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .out_data(out_data), .out_addr(out_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .wrap(wrap), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Combinational ROM model answering the DUT's address in the same cycle.
  always_comb begin
    mem_data = 32'hDEADBEEF;
    if (mem_addr < 32'd10) mem_data = rom_img[mem_addr[3:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkPair(input string tag, input logic [31:0] a, input logic [31:0] d);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_addr"}, out_addr, a);
    checkOutput({tag, "_data"}, out_data, d);
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic j, input logic [31:0] ja, input logic r);
    start = s; stop = p; jump_en = j; jump_addr = ja; out_ready = r;
  endtask

  initial begin
    rom_img[0] = 32'hA00000AA; rom_img[1] = 32'h10000011; rom_img[2] = 32'h20000022;
    rom_img[3] = 32'h30000033; rom_img[4] = 32'h40000044; rom_img[5] = 32'h50000055;
    rom_img[6] = 32'h60000066; rom_img[7] = 32'h70000077; rom_img[8] = 32'h80000088;
    rom_img[9] = 32'h90000099;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_data", out_data, 32'd0);
    checkOutput("rst_addr", out_addr, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_wrap", {31'd0, wrap}, 32'd0);
    checkOutput("rst_err", {31'd0, addr_err}, 32'd0);
    checkOutput("rst_pc", mem_addr, 32'd0);

    // Start and stream a full pass with no backpressure.
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("run_busy", {31'd0, busy}, 32'd1);
    checkOutput("run_first_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkPair($sformatf("stream%0d", i), 32'(i), rom_img[i]);
      checkOutput($sformatf("stream%0d_wrap", i), {31'd0, wrap}, (i == 9) ? 32'd1 : 32'd0);
    end
    tick();
    checkPair("after_wrap", 32'd0, 32'hA00000AA);
    checkOutput("after_wrap_wrap", {31'd0, wrap}, 32'd0);

    // Backpressure while word 2 is presented.
    tick();
    tick();
    checkPair("bp_pre", 32'd2, 32'h20000022);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkPair($sformatf("bp_hold%0d", i), 32'd2, 32'h20000022);
      checkOutput($sformatf("bp_pc%0d", i), mem_addr, 32'd3);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    checkPair("bp_release", 32'd3, 32'h30000033);

    // Legal jump gives one bubble then continues from the target.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd7, 1'b1);
    tick();
    checkOutput("jump_bubble", {31'd0, out_valid}, 32'd0);
    checkOutput("jump_pc", mem_addr, 32'd7);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    checkPair("jump_w7", 32'd7, 32'h70000077);
    tick();
    checkPair("jump_w8", 32'd8, 32'h80000088);

    // Out-of-range jump flags an error and leaves the sequence alone.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd12, 1'b1);
    tick();
    checkOutput("badjump_err", {31'd0, addr_err}, 32'd1);
    checkOutput("badjump_pc", mem_addr, 32'd9);
    checkOutput("badjump_bubble", {31'd0, out_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    checkPair("badjump_w9", 32'd9, 32'h90000099);
    checkOutput("badjump_sticky", {31'd0, addr_err}, 32'd1);
    checkOutput("badjump_wrap", {31'd0, wrap}, 32'd1);

    // Stop while the consumer stalls, then drain.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("drain_busy", {31'd0, busy}, 32'd1);
    checkPair("drain_hold", 32'd9, 32'h90000099);
    tick();
    checkOutput("drain_busy2", {31'd0, busy}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    checkOutput("drain_done_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("drain_done_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("idle_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("idle_pc", mem_addr, 32'd0);
    checkOutput("idle_err", {31'd0, addr_err}, 32'd1);

    // Restart clears the error; run to word 5, then reset mid-run.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("restart_err", {31'd0, addr_err}, 32'd0);
    checkOutput("restart_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkPair($sformatf("restart%0d", i), 32'(i), rom_img[i]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_data", out_data, 32'd0);
    checkOutput("midrst_pc", mem_addr, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_wrap", {31'd0, wrap}, 32'd0);

    // Jumps are ignored outside RUN.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd12, 1'b1);
    tick();
    checkOutput("idlejump_err", {31'd0, addr_err}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd4, 1'b1);
    tick();
    checkOutput("idlejump_pc", mem_addr, 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    checkPair("final_w0", 32'd0, 32'hA00000AA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_fetch_seq.md
Name: mem_fetch_seq

Overview:
- Read initiator for the team's combinational word ROM (addr in, data out same cycle).
- Sequentially walks word addresses and samples the returned word.
- Presents each {address, word} pair to a downstream consumer over a valid/ready handshake.
- Supports start/stop, jump (address reload), wrap at ROM depth, and downstream backpressure.

Parameters:
- DEPTH, 10, number of ROM words; valid addresses 0..DEPTH-1
- START_ADDR, 0, address loaded into PC at reset and on start
- DATA_W, 32, ROM word width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; IDLE->RUN, PC<=START_ADDR
- stop  in  1  one-cycle pulse; RUN->DRAIN
- jump_en  in  1  load PC from jump_addr (RUN only)
- jump_addr  in  32  jump target word address
- mem_addr  out  32  ROM address; always equals PC (combinational from PC register)
- mem_data  in  DATA_W  ROM word for mem_addr, valid same cycle
- out_data  out  DATA_W  captured word
- out_addr  out  32  address the captured word came from
- out_valid  out  1  out_data/out_addr hold an unconsumed pair
- out_ready  in  1  consumer accepts; transfer when out_valid&&out_ready
- busy  out  1  high in RUN or DRAIN
- wrap  out  1  one-cycle pulse when PC advances DEPTH-1 -> 0
- addr_err  out  1  sticky; set on out-of-range jump, cleared by rst or start

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, PC=START_ADDR, out_valid=0, out_data=0, out_addr=0, wrap=0, addr_err=0, busy=0. rst overrides every other input.
- cap = (state==RUN) && !jump_en && (!out_valid || out_ready).
- On cap: out_data<=mem_data, out_addr<=PC, out_valid<=1, PC<=(PC==DEPTH-1)?0:PC+1.
- Latency: one cycle from PC presentation to out_valid.
- Sustained throughput: one word per cycle while out_ready=1.
- Transfer without cap: out_valid<=0.
- Backpressure: out_valid&&!out_ready holds out_data, out_addr and PC stable. No word skipped, none duplicated.
- wrap<=1 exactly in the cycle after a cap with PC==DEPTH-1; otherwise 0.
- jump_en in RUN:
  - No capture that cycle; a pending out pair still transfers if out_ready.
  - jump_addr<DEPTH: PC<=jump_addr.
  - jump_addr>=DEPTH: PC unchanged, addr_err<=1.
- jump_en outside RUN: ignored.
- States:
  - IDLE: start -> RUN (PC<=START_ADDR, addr_err<=0).
  - RUN: stop -> DRAIN. A cap in the same cycle as stop still occurs (last word).
  - DRAIN: no captures; out_valid==0 -> IDLE. Leaves on the same edge a transfer clears out_valid.
  - start in RUN/DRAIN: ignored.
  - stop in IDLE: ignored.
  - stop and jump_en same cycle in RUN: stop wins state change, jump still updates PC.
- PC holds its value in IDLE; mem_addr keeps driving PC.
- Address widths: internal PC is 32 bits; comparison against DEPTH is unsigned 32-bit.

Test Plan:
- Bench ROM image: word0=A00000AA, word i=i000000i_i (i=1..9, e.g. word3=30000033).
- Run, no backpressure: rst, start, out_ready=1 -> out_valid rises 1 cycle after RUN; pairs (0,A00000AA),(1,10000011)…(9,90000099) on consecutive cycles; wrap pulses once after addr 9; next pair (0,A00000AA).
- Backpressure: out_ready=0 for 3 cycles while (2,20000022) valid -> out_data/out_addr/PC frozen; release -> (3,30000033) next cycle; no gap or duplicate.
- Jump: in RUN, jump_en with jump_addr=7 -> one bubble, then (7,70000077),(8,80000088); jump_addr=12 -> addr_err=1 and sticky; sequence unchanged; next start clears addr_err.
- Stop/drain: stop while out_valid=1 and out_ready=0 -> busy=1 in DRAIN; on transfer, out_valid=0, state IDLE, busy=0; no further captures.
- Reset mid-run: rst asserted with out_valid=1 at addr 5 -> next edge: out_valid=0, out_data=0, PC=0, busy=0, wrap=0; start then restarts at (0,A00000AA).
